surf_debug_capture: RTL and testbench

SURF_DEBUG_CAPTURE -- requirements
Module: surf_debug_capture

---
 rtl/surf_debug_capture.sv | 145 ++++++++++++++
 tb/tb_surf_debug_capture.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/surf_debug_capture.sv
// Debug-bus logic analyser: arm, trigger on mask/value or force, capture, then stream the buffer out.
// Latency: rd_valid_o rises 1 cycle after READOUT entry; 1-cycle buffer read, one word per cycle.
// Backpressure: rd_ready_i low holds rd_data_o/rd_last_o stable; capture itself cannot be stalled.
module surf_debug_capture #(
    parameter int DEPTH_LOG2 = 8,
    parameter int POST_TRIG  = 128
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic [34:0]           dbg_i,
    input  logic                  arm_i,
    input  logic                  force_trig_i,
    input  logic [34:0]           trig_mask_i,
    input  logic [34:0]           trig_value_i,
    output logic [34:0]           rd_data_o,
    output logic                  rd_valid_o,
    output logic                  rd_last_o,
    input  logic                  rd_ready_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [DEPTH_LOG2-1:0] trig_pos_o
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   LAST_CNT = (DEPTH_LOG2+1)'(POST_TRIG - 1);
    localparam logic [DEPTH_LOG2:0]   FULL_LEN = (DEPTH_LOG2+1)'(DEPTH);
    localparam logic [DEPTH_LOG2-1:0] PTR_MAX  = '1;

    typedef enum logic [1:0] {S_IDLE, S_ARMED, S_POST, S_READOUT} state_t;

    state_t                state_q, state_d;
    logic [34:0]           mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, trig_ptr_q, rd_ptr_q;
    logic                  wrapped_q;
    logic [DEPTH_LOG2:0]   post_cnt_q, rd_left_q;

    logic                  trig_hit, wr_en, xfer, fetch, wrapped_nxt;
    logic [DEPTH_LOG2-1:0] wr_ptr_inc, trig_ptr_eff, rd_start;

    assign trig_hit     = (state_q == S_ARMED) &&
                          (force_trig_i || (((dbg_i ^ trig_value_i) & trig_mask_i) == '0));
    assign wr_en        = (state_q == S_ARMED) || (state_q == S_POST);
    assign xfer         = rd_valid_o && rd_ready_i;
    assign fetch        = (state_q == S_READOUT) && (!rd_valid_o || rd_ready_i) && (rd_left_q != '0);
    assign wr_ptr_inc   = wr_ptr_q + 1'b1;
    assign wrapped_nxt  = wrapped_q || (wr_ptr_q == PTR_MAX);
    // When POST_TRIG is 1 the trigger sample is also the last one, so trig_ptr_q is not yet loaded.
    assign trig_ptr_eff = (state_q == S_ARMED) ? wr_ptr_q : trig_ptr_q;
    assign rd_start     = wrapped_nxt ? wr_ptr_inc : '0;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        busy_o  = 1'b0;
        done_o  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (arm_i) state_d = S_ARMED;
            end
            S_ARMED: begin
                busy_o = 1'b1;
                if (trig_hit) state_d = (POST_TRIG == 1) ? S_READOUT : S_POST;
            end
            S_POST: begin
                busy_o = 1'b1;
                if (post_cnt_q == LAST_CNT) state_d = S_READOUT;
            end
            S_READOUT: begin
                done_o = 1'b1;
                if (arm_i)                  state_d = S_ARMED;
                else if (xfer && rd_last_o) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (wr_en) mem[wr_ptr_q] <= dbg_i;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr_q   <= '0;
            trig_ptr_q <= '0;
            rd_ptr_q   <= '0;
            wrapped_q  <= 1'b0;
            post_cnt_q <= '0;
            rd_left_q  <= '0;
            trig_pos_o <= '0;
            rd_data_o  <= '0;
            rd_valid_o <= 1'b0;
            rd_last_o  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (arm_i) begin
                        wr_ptr_q   <= '0;
                        wrapped_q  <= 1'b0;
                        post_cnt_q <= '0;
                    end
                end
                S_ARMED, S_POST: begin
                    wr_ptr_q  <= wr_ptr_inc;
                    wrapped_q <= wrapped_nxt;
                    if (trig_hit) begin
                        trig_ptr_q <= wr_ptr_q;
                        post_cnt_q <= (DEPTH_LOG2+1)'(1);
                    end else if (state_q == S_POST) begin
                        post_cnt_q <= post_cnt_q + 1'b1;
                    end
                    if (state_d == S_READOUT) begin
                        rd_ptr_q   <= rd_start;
                        rd_left_q  <= wrapped_nxt ? FULL_LEN : {1'b0, wr_ptr_inc};
                        trig_pos_o <= trig_ptr_eff - rd_start;
                    end
                end
                S_READOUT: begin
                    if (arm_i) begin
                        wr_ptr_q   <= '0;
                        wrapped_q  <= 1'b0;
                        post_cnt_q <= '0;
                        rd_left_q  <= '0;
                        rd_valid_o <= 1'b0;
                        rd_last_o  <= 1'b0;
                    end else if (fetch) begin
                        rd_data_o  <= mem[rd_ptr_q];
                        rd_valid_o <= 1'b1;
                        rd_last_o  <= (rd_left_q == (DEPTH_LOG2+1)'(1));
                        rd_ptr_q   <= rd_ptr_q + 1'b1;
                        rd_left_q  <= rd_left_q - 1'b1;
                    end else if (xfer) begin
                        rd_valid_o <= 1'b0;
                        rd_last_o  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_surf_debug_capture.sv
// Bench for surf_debug_capture: stimulus pushes the expected readout stream, a monitor pops and compares.
module tb_surf_debug_capture;

    localparam int DL    = 4;
    localparam int PT    = 4;
    localparam int DEPTH = 16;

    logic          clk_i = 1'b0;
    logic          rst_n_i;
    logic [34:0]   dbg_i;
    logic          arm_i;
    logic          force_trig_i;
    logic [34:0]   trig_mask_i;
    logic [34:0]   trig_value_i;
    logic [34:0]   rd_data_o;
    logic          rd_valid_o;
    logic          rd_last_o;
    logic          rd_ready_i;
    logic          busy_o;
    logic          done_o;
    logic [DL-1:0] trig_pos_o;

    always #5 clk_i = ~clk_i;

    surf_debug_capture #(.DEPTH_LOG2(DL), .POST_TRIG(PT)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .dbg_i(dbg_i), .arm_i(arm_i),
        .force_trig_i(force_trig_i), .trig_mask_i(trig_mask_i), .trig_value_i(trig_value_i),
        .rd_data_o(rd_data_o), .rd_valid_o(rd_valid_o), .rd_last_o(rd_last_o),
        .rd_ready_i(rd_ready_i), .busy_o(busy_o), .done_o(done_o), .trig_pos_o(trig_pos_o)
    );

    typedef struct { logic [34:0] dat; logic last; } exp_t;
    exp_t exp_q[$];

    int vectors     = 0;
    int miscompares = 0;
    int xfer_total  = 0;

    localparam logic [34:0] ONES = '1;

    task automatic chk(input string name, input logic [34:0] act, input logic [34:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // dbg_i is a free-running count that restarts at 0 on the first cycle after an arm
    task automatic tick();
        @(posedge clk_i);
        #1;
        if (arm_i) dbg_i = '0;
        else       dbg_i = dbg_i + 1'b1;
    endtask

    // Monitor: transfers are judged at the negedge preceding the edge that completes them
    exp_t        mon_e;
    logic        prev_stall = 1'b0;
    logic [34:0] prev_dat;
    logic        prev_last;
    always @(negedge clk_i) begin
        if (rst_n_i) begin
            if (rd_valid_o && prev_stall) begin
                chk("hold_data", rd_data_o, prev_dat);
                chk("hold_last", 35'(rd_last_o), 35'(prev_last));
            end
            if (rd_valid_o && rd_ready_i) begin
                if (exp_q.size() > 0) begin
                    mon_e = exp_q.pop_front();
                    chk("rd_data", rd_data_o, mon_e.dat);
                    chk("rd_last", 35'(rd_last_o), 35'(mon_e.last));
                end else begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_word: got %0h expected none", rd_data_o);
                end
                xfer_total++;
            end
            prev_stall = rd_valid_o && !rd_ready_i;
            prev_dat   = rd_data_o;
            prev_last  = rd_last_o;
        end else begin
            prev_stall = 1'b0;
        end
    end

    // rmode: 0 always ready, 1 random ready, 2 three-cycle stall at word 5
    task automatic capture(input logic [34:0] mask, input logic [34:0] value, input bit fen,
                           input int fk, input int rmode, input int abort_at, input bit pre_armed);
        int ti, n, len, first, tpos, busy_cnt, cyc, stall, base;
        logic [34:0] kv;
        trig_mask_i  = mask;
        trig_value_i = value;
        ti = -1;
        for (int k = 0; k < 256 && ti < 0; k++) begin
            kv = 35'(k);
            if ((fen && k == fk) || (((kv ^ value) & mask) == 35'd0)) ti = k;
        end
        if (ti < 0) ti = 0;
        n     = ti + PT;
        len   = (n < DEPTH) ? n : DEPTH;
        first = n - len;
        tpos  = ti - first;
        for (int j = 0; j < len; j++) exp_q.push_back('{dat: 35'(first + j), last: (j == len - 1)});
        base = xfer_total;
        rd_ready_i = 1'b0;
        if (!pre_armed) begin
            arm_i = 1'b1;
            tick();
            arm_i = 1'b0;
        end
        force_trig_i = fen && (dbg_i == 35'(fk));
        busy_cnt = 0;
        cyc = 0;
        while (busy_o && cyc < 1000) begin
            busy_cnt++;
            tick();
            force_trig_i = fen && (dbg_i == 35'(fk));
            cyc++;
        end
        force_trig_i = 1'b0;
        chk("busy_cycles", 35'(busy_cnt), 35'(n));
        chk("done_at_entry", 35'(done_o), 35'd1);
        chk("trig_pos", 35'(trig_pos_o), 35'(tpos));
        tick();
        chk("valid_latency", 35'(rd_valid_o), 35'd1);
        stall = 0;
        cyc = 0;
        while ((exp_q.size() > 0 || rd_valid_o) && cyc < 1000) begin
            if (abort_at > 0 && xfer_total - base == abort_at) begin
                rd_ready_i = 1'b0;
                exp_q.delete();
                arm_i = 1'b1;
                tick();
                arm_i = 1'b0;
                chk("abort_valid_drop", 35'(rd_valid_o), 35'd0);
                chk("abort_rearmed", 35'(busy_o), 35'd1);
                return;
            end
            case (rmode)
                0: rd_ready_i = 1'b1;
                1: rd_ready_i = 1'($urandom_range(0, 1));
                default: begin
                    if (xfer_total - base == 5 && stall < 3) begin
                        rd_ready_i = 1'b0;
                        stall++;
                    end else begin
                        rd_ready_i = 1'b1;
                    end
                end
            endcase
            tick();
            cyc++;
        end
        rd_ready_i = 1'b0;
        chk("drained", 35'(exp_q.size()), 35'd0);
        chk("words_moved", 35'(xfer_total - base), 35'(len));
        chk("idle_done", 35'(done_o), 35'd0);
        chk("idle_valid", 35'(rd_valid_o), 35'd0);
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_busy"},  35'(busy_o),     35'd0);
        chk({tag, "_done"},  35'(done_o),     35'd0);
        chk({tag, "_valid"}, 35'(rd_valid_o), 35'd0);
        chk({tag, "_last"},  35'(rd_last_o),  35'd0);
        chk({tag, "_data"},  rd_data_o,       35'd0);
        chk({tag, "_tpos"},  35'(trig_pos_o), 35'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [34:0] m, v;
        bit fen;
        rst_n_i = 1'b0; dbg_i = '0; arm_i = 1'b0; force_trig_i = 1'b0;
        trig_mask_i = '0; trig_value_i = '0; rd_ready_i = 1'b0;
        tick(); tick();
        chk_zero_outputs("reset");
        rst_n_i = 1'b1;
        tick();

        capture('0, '0, 1'b0, 0, 0, 0, 1'b0);          // immediate trigger
        capture(ONES, 35'd20, 1'b0, 0, 0, 0, 1'b0);    // wrapped capture
        capture(ONES, 35'd20, 1'b0, 0, 2, 0, 1'b0);    // stall at word 5

        // reset in the middle of POST, then a clean capture
        trig_mask_i = '0;
        arm_i = 1'b1; tick(); arm_i = 1'b0;
        tick();
        chk("post_busy", 35'(busy_o), 35'd1);
        rst_n_i = 1'b0;
        #1;
        chk_zero_outputs("midpost_rst");
        tick();
        rst_n_i = 1'b1;
        tick();
        capture('0, '0, 1'b0, 0, 0, 0, 1'b0);

        capture(ONES, 35'd2, 1'b1, 2, 0, 0, 1'b0);     // force and match together
        capture(ONES, 35'd20, 1'b0, 0, 0, 4, 1'b0);    // abort after word 3
        capture('0, '0, 1'b0, 0, 1, 0, 1'b1);

        for (int it = 0; it < 20; it++) begin
            case ($urandom_range(0, 2))
                0: begin m = '0;   v = 35'($urandom); end
                1: begin m = ONES; v = 35'($urandom_range(0, 50)); end
                default: begin m = 35'($urandom & 32'h3F); v = {3'($urandom), 32'($urandom)}; end
            endcase
            fen = 1'($urandom_range(0, 1));
            capture(m, v, fen, $urandom_range(0, 40), 1, 0, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
